// File: rtl/nor_chain_stim_pkg.sv
// Shared types and constants for the NOR-chain pulse-train stimulus generator.
package nor_chain_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StFin
  } stim_state_e;

  localparam int unsigned LfsrW       = 16;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [LfsrW-1:0] LfsrTaps    = 16'hB400;
  localparam logic [LfsrW-1:0] DefaultSeed = 16'hACE1;

  function automatic logic [LfsrW-1:0] lfsr_step(input logic [LfsrW-1:0] v);
    return {v[LfsrW-2:0], ^(v & LfsrTaps)};
  endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only on request. A load can be combined with
// a step so that the seed supplies the current length and the next state is ready.
module stim_lfsr16
  import nor_chain_stim_pkg::*;
#(
  parameter logic [LfsrW-1:0] RESET_SEED = DefaultSeed,
  parameter int unsigned      OUT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LfsrW-1:0] seed_i,
  input  logic             adv_i,
  output logic [OUT_W-1:0] value_o
);

  logic [LfsrW-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= RESET_SEED;
    end else if (load_i) begin
      r_lfsr <= adv_i ? lfsr_step(seed_i) : seed_i;
    end else if (adv_i) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign value_o = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/nor_chain_pulse_stim.sv
// Pulse-train generator driving the NOR inverter-chain data input with fixed or
// LFSR-randomised high/low phase lengths; stim_o comes straight from a flop.
module nor_chain_pulse_stim
  import nor_chain_stim_pkg::*;
#(
  parameter int unsigned      WIDTH_W   = 8,
  parameter int unsigned      COUNT_W   = 16,
  parameter logic [LfsrW-1:0] LFSR_SEED = DefaultSeed
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               rand_i,
  input  logic [WIDTH_W-1:0] hi_len_i,
  input  logic [WIDTH_W-1:0] lo_len_i,
  input  logic [COUNT_W-1:0] num_i,
  input  logic [LfsrW-1:0]   seed_i,
  output logic               stim_o,
  output logic               stim_gnd_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] pulse_cnt_o
);

  stim_state_e        r_state;
  logic               r_stim;
  logic               r_busy;
  logic               r_done;
  logic [COUNT_W-1:0] r_pulse_cnt;
  logic [COUNT_W-1:0] r_num;
  logic [WIDTH_W-1:0] r_hi;
  logic [WIDTH_W-1:0] r_lo;
  logic               r_rand;
  logic [WIDTH_W-1:0] r_phase_cnt;

  logic               w_start_ok;
  logic               w_phase_end;
  logic               w_to_high;
  logic               w_to_low;
  logic [COUNT_W-1:0] w_cnt_inc;
  logic [LfsrW-1:0]   w_seed_eff;
  logic [WIDTH_W-1:0] w_lfsr;
  logic [WIDTH_W-1:0] w_len_raw;
  logic [WIDTH_W-1:0] w_phase_init;

  assign w_start_ok  = (r_state == StIdle) && start_i && !abort_i;
  assign w_phase_end = (r_phase_cnt == '0);
  assign w_cnt_inc   = (r_pulse_cnt == '1) ? r_pulse_cnt : r_pulse_cnt + COUNT_W'(1);
  assign w_seed_eff  = (seed_i == '0) ? LFSR_SEED : seed_i;

  assign w_to_high = (w_start_ok && (num_i != '0)) ||
                     ((r_state == StLow) && !abort_i && w_phase_end && (w_cnt_inc != r_num));
  assign w_to_low  = (r_state == StHigh) && !abort_i && w_phase_end;

  // On the start edge the effective seed itself supplies the first phase length.
  always_comb begin
    w_len_raw = '0;
    unique case (r_state)
      StIdle:  w_len_raw = rand_i ? w_seed_eff[WIDTH_W-1:0] : hi_len_i;
      StHigh:  w_len_raw = r_rand ? w_lfsr : r_lo;
      StLow:   w_len_raw = r_rand ? w_lfsr : r_hi;
      default: w_len_raw = '0;
    endcase
  end

  // Counter holds L-1; a zero length behaves as one cycle.
  assign w_phase_init = (w_len_raw == '0) ? '0 : w_len_raw - WIDTH_W'(1);

  stim_lfsr16 #(
    .RESET_SEED (LFSR_SEED),
    .OUT_W      (WIDTH_W)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_start_ok),
    .seed_i  (w_seed_eff),
    .adv_i   (w_to_high || w_to_low),
    .value_o (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_stim      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse_cnt <= '0;
      r_num       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_rand      <= 1'b0;
      r_phase_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (w_start_ok) begin
            r_hi        <= hi_len_i;
            r_lo        <= lo_len_i;
            r_num       <= num_i;
            r_rand      <= rand_i;
            r_pulse_cnt <= '0;
            if (num_i == '0) begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StHigh;
              r_stim      <= 1'b1;
              r_busy      <= 1'b1;
              r_phase_cnt <= w_phase_init;
            end
          end
        end
        StHigh: begin
          if (abort_i) begin
            r_state <= StIdle;
            r_stim  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
            r_state     <= StLow;
            r_stim      <= 1'b0;
            r_phase_cnt <= w_phase_init;
          end else begin
            r_phase_cnt <= r_phase_cnt - WIDTH_W'(1);
          end
        end
        StLow: begin
          if (abort_i) begin
            r_state <= StIdle;
            r_stim  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
            r_pulse_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_num) begin
              r_state <= StFin;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StHigh;
              r_stim      <= 1'b1;
              r_phase_cnt <= w_phase_init;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt - WIDTH_W'(1);
          end
        end
        StFin: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_stim  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign stim_o      = r_stim;
  assign stim_gnd_o  = 1'b0;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pulse_cnt_o = r_pulse_cnt;

endmodule

// File: tb/tb_nor_chain_pulse_stim.sv
// Scoreboard bench: a cycle model pushes expected per-cycle outputs, the DUT trace pops them.
module tb_nor_chain_pulse_stim;

  typedef struct packed {
    logic        stim;
    logic        busy;
    logic        done;
    logic [15:0] pcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic        rand_i;
  logic [7:0]  hi_len_i;
  logic [7:0]  lo_len_i;
  logic [15:0] num_i;
  logic [15:0] seed_i;
  logic        stim_o;
  logic        stim_gnd_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pulse_cnt_o;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nor_chain_pulse_stim dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .rand_i      (rand_i),
    .hi_len_i    (hi_len_i),
    .lo_len_i    (lo_len_i),
    .num_i       (num_i),
    .seed_i      (seed_i),
    .stim_o      (stim_o),
    .stim_gnd_o  (stim_gnd_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected outputs for cycles 1.. after the start edge, plus one idle cycle after done.
  task automatic push_model(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] num,
                            input logic rnd, input logic [15:0] seed);
    logic [15:0] lf;
    logic [7:0]  len;
    lf = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int p = 0; p < int'(num); p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        len = rnd ? lf[7:0] : ((ph == 0) ? hi : lo);
        if (len == 8'd0) len = 8'd1;
        lf = ref_step(lf);
        for (int k = 0; k < int'(len); k++)
          sb_q.push_back(exp_t'{stim: (ph == 0), busy: 1'b1, done: 1'b0, pcnt: 16'(p)});
      end
    end
    sb_q.push_back(exp_t'{stim: 1'b0, busy: 1'b0, done: 1'b1, pcnt: num});
    sb_q.push_back(exp_t'{stim: 1'b0, busy: 1'b0, done: 1'b0, pcnt: num});
  endtask

  task automatic launch(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] num,
                        input logic rnd, input logic [15:0] seed);
    @(negedge clk);
    hi_len_i = hi;
    lo_len_i = lo;
    num_i    = num;
    rand_i   = rnd;
    seed_i   = seed;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Pops one expectation per cycle. abort_at/poke_at raise abort_i or start_i in that cycle.
  task automatic drain(input string name, input int abort_at, input int poke_at);
    exp_t e;
    exp_t obs;
    int   cyc;
    cyc = 1;
    while (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      obs = {stim_o, busy_o, done_o, pulse_cnt_o};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got stim=%b busy=%b done=%b cnt=%0d exp stim=%b busy=%b done=%b cnt=%0d",
                 name, cyc, obs.stim, obs.busy, obs.done, obs.pcnt, e.stim, e.busy, e.done, e.pcnt);
      end
      if (cyc == abort_at) begin
        abort_i = 1'b1;
        sb_q.delete();
        repeat (4) sb_q.push_back(exp_t'{stim: 1'b0, busy: 1'b0, done: 1'b0, pcnt: e.pcnt});
      end
      if (cyc == poke_at) begin
        start_i  = 1'b1;
        num_i    = 16'd1;
        hi_len_i = 8'd1;
        lo_len_i = 8'd7;
      end
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      start_i = 1'b0;
      cyc++;
    end
  endtask

  task automatic run_train(input string name, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [15:0] num, input logic rnd, input logic [15:0] seed,
                           input int abort_at, input int poke_at);
    push_model(hi, lo, num, rnd, seed);
    launch(hi, lo, num, rnd, seed);
    drain(name, abort_at, poke_at);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    rand_i   = 1'b0;
    hi_len_i = '0;
    lo_len_i = '0;
    num_i    = '0;
    seed_i   = '0;
    #3;
    checks++;
    if ({stim_o, stim_gnd_o, busy_o, done_o, pulse_cnt_o} !== 20'h0) begin
      errors++;
      $display("FAIL reset got stim=%b gnd=%b busy=%b done=%b cnt=%0d exp all 0",
               stim_o, stim_gnd_o, busy_o, done_o, pulse_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    run_train("fixed_3_2_4", 8'd3, 8'd2, 16'd4, 1'b0, 16'h0, 0, 0);
  endtask

  task automatic test_num_zero();
    run_train("num_zero", 8'd3, 8'd2, 16'd0, 1'b0, 16'h0, 0, 0);
  endtask

  task automatic test_zero_len();
    run_train("zero_len", 8'd0, 8'd0, 16'd3, 1'b0, 16'h0, 0, 0);
  endtask

  task automatic test_rand();
    run_train("rand_seed1_a", 8'd9, 8'd9, 16'd5, 1'b1, 16'h0001, 0, 0);
    run_train("rand_seed1_b", 8'd9, 8'd9, 16'd5, 1'b1, 16'h0001, 0, 0);
    run_train("rand_seed0", 8'd9, 8'd9, 16'd2, 1'b1, 16'h0000, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_train("start_while_busy", 8'd3, 8'd2, 16'd4, 1'b0, 16'h0, 0, 5);
    run_train("back_to_back", 8'd1, 8'd2, 16'd2, 1'b0, 16'h0, 0, 0);
  endtask

  task automatic test_abort();
    // Cycle 10 lies in the second HIGH phase (cycles 9..12) with one pulse completed.
    run_train("abort_high2", 8'd4, 8'd4, 16'd10, 1'b0, 16'h0, 10, 0);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    num_i   = 16'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) sb_q.push_back(exp_t'{stim: 1'b0, busy: 1'b0, done: 1'b0, pcnt: 16'd1});
    drain("abort_beats_start", 0, 0);
  endtask

  task automatic test_async_reset();
    launch(8'd3, 8'd2, 16'd4, 1'b0, 16'h0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({stim_o, busy_o, pulse_cnt_o} !== {1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL pre_reset_low got stim=%b busy=%b cnt=%0d exp stim=0 busy=1 cnt=1",
               stim_o, busy_o, pulse_cnt_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stim_o, stim_gnd_o, busy_o, done_o, pulse_cnt_o} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got stim=%b gnd=%b busy=%b done=%b cnt=%0d exp all 0",
               stim_o, stim_gnd_o, busy_o, done_o, pulse_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_train("after_reset", 8'd3, 8'd2, 16'd4, 1'b0, 16'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_num_zero();
    test_zero_len();
    test_rand();
    test_back_to_back();
    test_abort();
    test_abort_start_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
